regfile_mp_sb: RTL and testbench

//  Parametrised multi-port register file with per-register scoreboard; the next-generation

---
 rtl/regfile_mp_sb_if.sv | 30 +++
 rtl/regfile_mp_sb.sv | 84 ++++++++
 tb/tb_regfile_mp_sb.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for regfile_mp_sb: write ports, read ports, reservation port and busy vector.
// The register file takes the slave view; the pipeline/issue logic drives the master view.
interface regfile_mp_sb_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*N-1:0]      wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*N-1:0]      rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [DEPTH-1:0]         busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-register busy scoreboard for hazard stalls.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_sb #(
  parameter int N        = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rstn,
  regfile_mp_sb_if.slave    bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [N-1:0]      r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W-1:0] w_waddr [NUM_WR];
  logic [N-1:0]      w_wdata [NUM_WR];
  logic [ADDR_W-1:0] w_raddr [NUM_RD];

  always_comb begin
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      w_waddr[k] = bus.wr_addr[k*ADDR_W +: ADDR_W];
      w_wdata[k] = bus.wr_data[k*N +: N];
    end
    for (int unsigned j = 0; j < NUM_RD; j++) begin
      w_raddr[j] = bus.rd_addr[j*ADDR_W +: ADDR_W];
    end
  end

  // Reservation is applied after write-retirement so a new producer supersedes a retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (bus.wr_en[k]) w_busy_nxt[w_waddr[k]] = 1'b0;
    end
    if (bus.rsv_en) w_busy_nxt[bus.rsv_addr] = 1'b1;
    if (ZR) w_busy_nxt[0] = 1'b0;
  end

  // Ascending port order lets the highest-index write to a shared address land last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        r_regs[r] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en[k] && !(ZR && w_waddr[k] == '0)) begin
          r_regs[w_waddr[k]] <= w_wdata[k];
        end
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.busy_vec = r_busy;

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int unsigned j = 0; j < NUM_RD; j++) begin
      bus.rd_data[j*N +: N] = r_regs[w_raddr[j]];
      bus.rd_busy[j]        = r_busy[w_raddr[j]];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en[k] && w_waddr[k] == w_raddr[j]) begin
          bus.rd_data[j*N +: N] = w_wdata[k];
          bus.rd_busy[j] = (bus.rsv_en && bus.rsv_addr == w_raddr[j]) ?
                           r_busy[w_raddr[j]] : 1'b0;
        end
      end
`endif
      if (ZR && w_raddr[j] == '0) begin
        bus.rd_data[j*N +: N] = '0;
        bus.rd_busy[j]        = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (default configuration, ZERO_REG=1).
module tb_regfile_mp_sb;
  localparam int N = 32, AW = 5, NRD = 2, NWR = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_sb_if #(.N(N), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

  regfile_mp_sb #(.N(N), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR), .ZERO_REG(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]  wr_en;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv;
    logic [4:0]  ra;
    logic [4:0]  rd0a;
    logic [4:0]  rd1a;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  ebusy;
    logic [31:0] ebv;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_en    = '0;
    bus.rsv_en   = 1'b0;
  endtask

  initial begin
    bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr = '0; bus.rsv_en = 1'b0; bus.rsv_addr = '0;

    vecs[0] = '{2'd0, 5'd0,  32'h0,         5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd1,
                32'h0,         32'h0,         2'b00, 32'h0};
    vecs[1] = '{2'd3, 5'd1,  32'h1111_1111, 5'd2,  32'h2222_2222, 1'b0, 5'd0,  5'd1,  5'd2,
                32'h1111_1111, 32'h2222_2222, 2'b00, 32'h0};
    vecs[2] = '{2'd3, 5'd7,  32'h11,        5'd7,  32'h22,        1'b0, 5'd0,  5'd7,  5'd1,
                32'h22,        32'h1111_1111, 2'b00, 32'h0};
    vecs[3] = '{2'd0, 5'd0,  32'h0,         5'd0,  32'h0,         1'b1, 5'd3,  5'd3,  5'd7,
                32'h0,         32'h22,        2'b01, 32'h0000_0008};
    vecs[4] = '{2'd1, 5'd4,  32'h9,         5'd0,  32'h0,         1'b1, 5'd4,  5'd4,  5'd3,
                32'h9,         32'h0,         2'b11, 32'h0000_0018};
    vecs[5] = '{2'd2, 5'd0,  32'h0,         5'd3,  32'h55,        1'b0, 5'd0,  5'd3,  5'd4,
                32'h55,        32'h9,         2'b10, 32'h0000_0010};
    vecs[6] = '{2'd1, 5'd0,  32'hFFFF_FFFF, 5'd0,  32'h0,         1'b1, 5'd0,  5'd0,  5'd4,
                32'h0,         32'h9,         2'b10, 32'h0000_0010};
    vecs[7] = '{2'd3, 5'd31, 32'hCAFE_F00D, 5'd30, 32'h3030,      1'b0, 5'd0,  5'd31, 5'd30,
                32'hCAFE_F00D, 32'h3030,      2'b00, 32'h0000_0010};
    vecs[8] = '{2'd1, 5'd4,  32'h44,        5'd0,  32'h0,         1'b0, 5'd0,  5'd4,  5'd31,
                32'h44,        32'hCAFE_F00D, 2'b00, 32'h0};
    vecs[9] = '{2'd3, 5'd31, 32'h66,        5'd31, 32'h77,        1'b1, 5'd31, 5'd31, 5'd4,
                32'h77,        32'h44,        2'b01, 32'h8000_0000};

    #1;
    chk("reset_rd0", bus.rd_data[31:0], 32'h0);
    chk("reset_bv", bus.busy_vec, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.wr_en    = vecs[i].wr_en;
      bus.wr_addr  = {vecs[i].wa1, vecs[i].wa0};
      bus.wr_data  = {vecs[i].wd1, vecs[i].wd0};
      bus.rsv_en   = vecs[i].rsv;
      bus.rsv_addr = vecs[i].ra;
      bus.rd_addr  = {vecs[i].rd1a, vecs[i].rd0a};
      @(posedge clk);
      #1 idle_inputs();
      #1;
      chk($sformatf("v%0d_rd0", i), bus.rd_data[31:0], vecs[i].e0);
      chk($sformatf("v%0d_rd1", i), bus.rd_data[63:32], vecs[i].e1);
      chk($sformatf("v%0d_busy", i), {30'b0, bus.rd_busy}, {30'b0, vecs[i].ebusy});
      chk($sformatf("v%0d_bv", i), bus.busy_vec, vecs[i].ebv);
    end

    // Reserve r12, two idle cycles, then the producer writes back.
    @(negedge clk);
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd12; bus.rd_addr = {5'd0, 5'd12};
    @(posedge clk);
    #1 idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rsv_busy_c%0d", c), {31'b0, bus.rd_busy[0]}, 32'h1);
      if (c == 2) begin
        bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd12}; bus.wr_data = {32'h0, 32'h55};
      end
    end
    @(posedge clk);
    #1 idle_inputs();
    #1;
    chk("rsv_busy_after", {31'b0, bus.rd_busy[0]}, 32'h0);
    chk("rsv_data_after", bus.rd_data[31:0], 32'h55);

    // Same-cycle read of a register being written (r9 untouched so far).
    @(negedge clk);
    bus.wr_en = 2'b10; bus.wr_addr = {5'd9, 5'd0}; bus.wr_data = {32'hABCD, 32'h0};
    bus.rd_addr = {5'd0, 5'd9};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_rd", bus.rd_data[31:0], 32'hABCD);
`else
    chk("bypass_rd", bus.rd_data[31:0], 32'h0);
`endif
    chk("bypass_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
    @(posedge clk);
    #1 idle_inputs();
    #1 chk("bypass_after", bus.rd_data[31:0], 32'hABCD);

    // Asynchronous reset mid-cycle, with a write held during reset.
    @(negedge clk);
    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd5}; bus.wr_data = {32'h0, 32'hDEAD_BEEF};
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd6; bus.rd_addr = {5'd6, 5'd5};
    @(posedge clk);
    #1 idle_inputs();
    #1;
    chk("pre_rst_r5", bus.rd_data[31:0], 32'hDEAD_BEEF);
    chk("pre_rst_bv", bus.busy_vec, 32'h8000_0040);
    #1 rstn = 1'b0;
    #1;
    chk("rst_rd0", bus.rd_data[31:0], 32'h0);
    chk("rst_rd1", bus.rd_data[63:32], 32'h0);
    chk("rst_bv", bus.busy_vec, 32'h0);
    @(negedge clk);
    bus.wr_en = 2'b01; bus.wr_addr = {5'd0, 5'd5}; bus.wr_data = {32'h0, 32'h1234};
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_r5", bus.rd_data[31:0], 32'h0);
    chk("post_rst_bv", bus.busy_vec, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
